// File: rtl/baud_gen_multi.sv
// UART baud generator: table/custom divisor, oversample tick, bit tick, square-wave baud_out.
// Latency: all outputs registered (1 cycle); free-running source, no backpressure.
module baud_gen_multi #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             resync_i,
    input  logic [2:0]       baud_sel_i,
    input  logic [CNT_W-1:0] div_custom_i,
    output logic [CNT_W-1:0] active_div_o,
    output logic             os_tick_o,
    output logic             bit_tick_o,
    output logic             baud_out_o
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);

    function automatic longint unsigned div_of(input longint unsigned baud);
        longint unsigned den;
        den = longint'(OVERSAMPLE) * baud;
        return (longint'(CLK_FREQ) + den / 2) / den;
    endfunction

    localparam longint unsigned DIV0 = div_of(2400);
    localparam longint unsigned DIV1 = div_of(4800);
    localparam longint unsigned DIV2 = div_of(9600);
    localparam longint unsigned DIV3 = div_of(19200);
    localparam longint unsigned DIV4 = div_of(38400);
    localparam longint unsigned DIV5 = div_of(57600);
    localparam longint unsigned DIV6 = div_of(115200);

    // The slowest rate has the largest divisor, so checking it covers the whole table.
    if (OVERSAMPLE < 2) begin : g_bad_os
        $error("baud_gen_multi: OVERSAMPLE must be >= 2");
    end
    if (DIV0 > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cnt_w
        $error("baud_gen_multi: CNT_W too narrow for table divisors");
    end

    logic [CNT_W-1:0] raw_div;
    logic [CNT_W-1:0] next_div;

    always_comb begin
        raw_div = div_custom_i;
        case (baud_sel_i)
            3'd0:    raw_div = CNT_W'(DIV0);
            3'd1:    raw_div = CNT_W'(DIV1);
            3'd2:    raw_div = CNT_W'(DIV2);
            3'd3:    raw_div = CNT_W'(DIV3);
            3'd4:    raw_div = CNT_W'(DIV4);
            3'd5:    raw_div = CNT_W'(DIV5);
            3'd6:    raw_div = CNT_W'(DIV6);
            default: raw_div = div_custom_i;
        endcase
        next_div = (raw_div < CNT_W'(2)) ? CNT_W'(2) : raw_div;
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [CNT_W-1:0] active_div_q, active_div_d;
    logic             os_tick_q, os_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             baud_out_q, baud_out_d;
    logic             wrap;

    assign wrap = (cnt_q == (active_div_q - 1'b1));

    always_comb begin
        cnt_d        = cnt_q;
        os_cnt_d     = os_cnt_q;
        active_div_d = active_div_q;
        os_tick_d    = 1'b0;
        bit_tick_d   = 1'b0;
        baud_out_d   = baud_out_q;
        if (!enable_i) begin
            cnt_d        = '0;
            os_cnt_d     = '0;
            baud_out_d   = 1'b0;
            active_div_d = next_div;
        end else if (resync_i) begin
            cnt_d      = '0;
            os_cnt_d   = '0;
            baud_out_d = 1'b1;
        end else begin
            // Divisor only changes at the wrap so no period is ever cut short or stretched.
            if (wrap) begin
                cnt_d        = '0;
                os_tick_d    = 1'b1;
                active_div_d = next_div;
                if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
                    os_cnt_d   = '0;
                    bit_tick_d = 1'b1;
                end else begin
                    os_cnt_d = os_cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            baud_out_d = ({1'b0, cnt_d} < (({1'b0, active_div_d} + 1'b1) >> 1));
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q        <= '0;
            os_cnt_q     <= '0;
            active_div_q <= next_div;
            os_tick_q    <= 1'b0;
            bit_tick_q   <= 1'b0;
            baud_out_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            os_cnt_q     <= os_cnt_d;
            active_div_q <= active_div_d;
            os_tick_q    <= os_tick_d;
            bit_tick_q   <= bit_tick_d;
            baud_out_q   <= baud_out_d;
        end
    end

    assign active_div_o = active_div_q;
    assign os_tick_o    = os_tick_q;
    assign bit_tick_o   = bit_tick_q;
    assign baud_out_o   = baud_out_q;

endmodule

// File: tb/tb_baud_gen_multi.sv
// Directed and randomized bench for baud_gen_multi against a cycle-level reference model.
module tb_baud_gen_multi;

    localparam int CLK_FREQ = 50_000_000;
    localparam int OS       = 16;
    localparam int CNT_W    = 16;

    logic             clock  = 1'b0;
    logic             reset  = 1'b1;
    logic             enable = 1'b0;
    logic             resync = 1'b0;
    logic [2:0]       sel    = 3'd0;
    logic [CNT_W-1:0] custom = '0;
    logic [CNT_W-1:0] active_div;
    logic             os_tick;
    logic             bit_tick;
    logic             baud_out;

    int errors = 0;
    int checks = 0;
    int n, hi, r;
    logic b0;

    // Reference model state: position inside the current divisor period and os ticks in the bit.
    int m_phase, m_ticks, m_div;
    bit m_os, m_bit, m_baud;

    always #5 clock = ~clock;

    baud_gen_multi #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OS),
        .CNT_W      (CNT_W)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .enable_i     (enable),
        .resync_i     (resync),
        .baud_sel_i   (sel),
        .div_custom_i (custom),
        .active_div_o (active_div),
        .os_tick_o    (os_tick),
        .bit_tick_o   (bit_tick),
        .baud_out_o   (baud_out)
    );

    function automatic int ref_div(input int s, input int c);
        int rate;
        int d;
        case (s)
            0: rate = 2400;
            1: rate = 4800;
            2: rate = 9600;
            3: rate = 19200;
            4: rate = 38400;
            5: rate = 57600;
            default: rate = 115200;
        endcase
        if (s == 7) d = c;
        else d = int'($floor(real'(CLK_FREQ) / (real'(OS) * real'(rate)) + 0.5));
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_edge();
        int nd;
        nd = ref_div(int'(sel), int'(custom));
        if (reset || !enable) begin
            m_phase = 0; m_ticks = 0; m_div = nd;
            m_os = 0; m_bit = 0; m_baud = 0;
        end else if (resync) begin
            m_phase = 0; m_ticks = 0;
            m_os = 0; m_bit = 0; m_baud = 1;
        end else begin
            m_phase++;
            m_os = 0; m_bit = 0;
            if (m_phase == m_div) begin
                m_phase = 0;
                m_os = 1;
                m_div = nd;
                m_ticks++;
                if (m_ticks == OS) begin
                    m_bit = 1;
                    m_ticks = 0;
                end
            end
            m_baud = (m_phase * 2 < m_div);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        chk("active_div", int'(active_div), m_div);
        chk("os_tick", int'(os_tick), int'(m_os));
        chk("bit_tick", int'(bit_tick), int'(m_bit));
        chk("baud_out", int'(baud_out), int'(m_baud));
    endtask

    // Cycles until the chosen tick (0 = os_tick, 1 = bit_tick) is seen; -1 when the budget runs out.
    task automatic cycles_to(input int which, input int limit, output int cnt);
        cnt = -1;
        for (int i = 1; i <= limit; i++) begin
            cyc();
            if ((which == 0) ? os_tick : bit_tick) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic restart(input logic [2:0] s, input int c);
        sel = s; custom = CNT_W'(c); enable = 1'b1; resync = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        // Custom divisor 4 from reset.
        restart(3'd7, 4);
        chk("rst_active_div", int'(active_div), 4);
        chk("rst_os_tick", int'(os_tick), 0);
        chk("rst_baud_out", int'(baud_out), 0);
        cycles_to(0, 20, n);  chk("t1_first_os", n, 4);
        cycles_to(0, 20, n);  chk("t1_os_period", n, 4);
        cycles_to(1, 200, n); chk("t1_first_bit_at64", n + 8, 64);
        cycles_to(1, 200, n); chk("t1_bit_period", n, 64);

        // 9600 baud from the table.
        restart(3'd2, 0);
        chk("t2_active_div", int'(active_div), 326);
        cycles_to(0, 400, n);  chk("t2_first_os", n, 326);
        cycles_to(1, 6000, n); chk("t2_first_bit", n + 326, 5216);
        cycles_to(1, 6000, n); chk("t2_bit_period", n, 5216);
        hi = 0;
        for (int i = 0; i < 326; i++) begin
            hi += int'(baud_out);
            cyc();
        end
        chk("t2_baud_high", hi, 163);

        // Divisor change mid-period takes effect only at the wrap.
        restart(3'd7, 10);
        for (int i = 0; i < 20 && m_phase != 3; i++) cyc();
        custom = CNT_W'(6);
        cyc();
        chk("t3_div_held", int'(active_div), 10);
        cycles_to(0, 20, n); chk("t3_cur_period", n + 4, 10);
        chk("t3_div_new", int'(active_div), 6);
        cycles_to(0, 20, n); chk("t3_next_period", n, 6);
        cycles_to(0, 20, n); chk("t3_next_period2", n, 6);

        // Divisors below 2 clamp to 2.
        for (int c = 0; c < 2; c++) begin
            restart(3'd7, c);
            chk("t4_clamp_div", int'(active_div), 2);
            cycles_to(0, 10, n); chk("t4_first_os", n, 2);
            cycles_to(0, 10, n); chk("t4_os_period", n, 2);
            b0 = baud_out;
            cyc();
            chk("t4_baud_alt", int'(baud_out), int'(!b0));
        end

        // Resync at cnt=5 with divisor 8.
        restart(3'd7, 8);
        for (int i = 0; i < 20 && m_phase != 5; i++) cyc();
        resync = 1'b1;
        cyc();
        resync = 1'b0;
        chk("t5_resync_baud", int'(baud_out), 1);
        chk("t5_resync_os", int'(os_tick), 0);
        cycles_to(0, 20, n);  chk("t5_os_after_resync", n, 8);
        cycles_to(1, 300, n); chk("t5_bit_after_resync", n + 8, 128);

        // Enable drop mid-bit, then reset with enable high.
        restart(3'd7, 4);
        for (int i = 0; i < 30; i++) cyc();
        enable = 1'b0;
        cyc();
        chk("t6_dis_baud", int'(baud_out), 0);
        chk("t6_dis_os", int'(os_tick), 0);
        enable = 1'b1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_rst_baud", int'(baud_out), 0);
        chk("t6_rst_bit", int'(bit_tick), 0);
        cycles_to(0, 20, n);  chk("t6_first_os", n, 4);
        cycles_to(1, 200, n); chk("t6_first_bit_at64", n + 4, 64);

        // Randomized traffic: rate switches, custom divisors, resyncs, enable drops, resets.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            reset  = (r == 0);
            enable = !(r >= 1 && r <= 3);
            resync = (r >= 4 && r <= 6);
            if ($urandom_range(0, 19) == 0) sel = 3'($urandom_range(4, 7));
            if ($urandom_range(0, 9) == 0) custom = CNT_W'($urandom_range(0, 12));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
